// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared constants and types for the 7:1 write-back mux arbiter.
//   NUM_REQ   : number of requesters / mux inputs
//   SEL_W     : width of the mux select
//   SEL_NONE  : select value used while idle (mux drives 32'd0)
//   state_t   : arbiter FSM states (IDLE, BUSY)
//   idx_to_onehot : converts a requester index to a one-hot grant vector

package mux_arb_pkg;

    localparam int NUM_REQ = 7;
    localparam int SEL_W   = 3;
    localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Indices outside 0..NUM_REQ-1 (i.e. SEL_NONE) map to an all-zero grant.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        if (int'(idx) < NUM_REQ) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_priority_7.sv
// rr_priority_7
// Purely combinational round-robin search over 7 requesters.
// The search starts at (Ptr+1) mod 7 and wraps 6->0, so the requester at
// Ptr itself is examined last.
// Ports:
//   Req   [6:0] in  : request vector to search
//   Ptr   [2:0] in  : last granted index (0..6)
//   index [2:0] out : winning index, SEL_NONE when nothing is found
//   found       out : high when any Req bit is set

module rr_priority_7
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] Req,
    input  logic [SEL_W-1:0]   Ptr,
    output logic [SEL_W-1:0]   index,
    output logic               found
);

    // cand[k] is the index examined at search offset k (k = 1 is first).
    logic [SEL_W-1:0]   cand [1:NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 1; gi <= NUM_REQ; gi++) begin : g_cand
            logic [SEL_W:0] sum;
            assign sum = {1'b0, Ptr} + (SEL_W+1)'(gi);
            // (Ptr + k) mod 7 with a single conditional subtract; sum <= 13.
            assign cand[gi] = (sum >= (SEL_W+1)'(NUM_REQ))
                            ? SEL_W'(sum - (SEL_W+1)'(NUM_REQ))
                            : sum[SEL_W-1:0];
            assign hit[gi-1] = Req[cand[gi]];
        end
    endgenerate

    // Walk from the lowest-priority offset up so the nearest hit wins.
    always_comb begin
        index = SEL_NONE;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (hit[k-1]) begin
                index = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Round-robin arbiter driving the select of a shared 32-bit 7:1 write-back
// mux. A grant is held until the consumer signals Done; on Done the next
// pending requester (finishing one has lowest priority) is granted on the
// same edge, otherwise the arbiter returns to IDLE.
//
// Optional feature: define ARB_TIMEOUT_EN to add a grant watchdog that
// revokes a grant held TIMEOUT_CYCLES cycles without Done and pulses Timeout.
//
// Ports:
//   clk          in  : clock, rising edge
//   reset_n      in  : asynchronous active-low reset
//   Req    [6:0] in  : per-requester request (bit i = mux input Ii)
//   Done         in  : consumer accepted the current transfer this cycle
//   Grant  [6:0] out : one-hot grant, zero when idle
//   Select [2:0] out : mux select = granted index, 3'b111 when idle
//   Valid        out : a grant is held
//   Timeout      out : one-cycle pulse when the watchdog revokes a grant

module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Done,
    output logic [NUM_REQ-1:0] Grant,
    output logic [SEL_W-1:0]   Select,
    output logic               Valid,
    output logic               Timeout
);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [SEL_W-1:0]   select_reg, select_next;
    logic               timeout_reg, timeout_next;

    logic [NUM_REQ-1:0] arb_req;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic               wd_expire;
    logic               xfer_end;
    logic               grant_issue;

    // The current owner is masked out so a finishing requester that keeps
    // requesting cannot be re-granted; in IDLE grant_reg is zero anyway.
    assign arb_req = Req & ~grant_reg;

    rr_priority_7 u_rr (
        .Req   (arb_req),
        .Ptr   (ptr_reg),
        .index (win_idx),
        .found (win_found)
    );

    assign xfer_end    = (state_reg == BUSY) && (Done || wd_expire);
    assign grant_issue = win_found && ((state_reg == IDLE) || xfer_end);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;

    assign wd_expire = (state_reg == BUSY) && !Done
                    && (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (grant_issue) begin
            wd_cnt_next = '0;
        end else if ((state_reg == BUSY) && !Done) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end
`else
    // Without the watchdog a grant is held until Done.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= SEL_W'(NUM_REQ - 1);
            grant_reg   <= '0;
            select_reg  <= SEL_NONE;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            select_reg  <= select_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (xfer_end && !win_found) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / pointer logic.
    always_comb begin
        grant_next   = grant_reg;
        select_next  = select_reg;
        ptr_next     = ptr_reg;
        timeout_next = wd_expire;
        if (grant_issue) begin
            grant_next  = idx_to_onehot(win_idx);
            select_next = win_idx;
            ptr_next    = win_idx;
        end else if (xfer_end) begin
            grant_next  = '0;
            select_next = SEL_NONE;
        end
    end

    assign Grant   = grant_reg;
    assign Select  = select_reg;
    assign Valid   = (state_reg == BUSY);
    assign Timeout = timeout_reg;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a rule-level model of the arbiter.

module tb_mux_sel_arbiter;

    localparam int TO_CYC = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] Req     = '0;
    logic       Done    = 1'b0;
    logic [6:0] Grant;
    logic [2:0] Select;
    logic       Valid;
    logic       Timeout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Req     (Req),
        .Done    (Done),
        .Grant   (Grant),
        .Select  (Select),
        .Valid   (Valid),
        .Timeout (Timeout)
    );

    // ---------------- behavioural model ----------------
    bit m_held  = 1'b0;
    int m_owner = 0;
    int m_last  = 6;
    int m_age   = 0;
    bit m_to    = 1'b0;
    int m_w;
    bit m_expire;

    // First requester found scanning last+1, last+2, ... (mod 7), skipping excl.
    function automatic int pick(logic [6:0] r, int last, int excl);
        for (int k = 1; k <= 7; k++) begin
            int i;
            i = (last + k) % 7;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [6:0] exp_grant();
        return m_held ? (7'd1 << m_owner) : 7'd0;
    endfunction

    function automatic logic [2:0] exp_sel();
        return m_held ? 3'(m_owner) : 3'd7;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_held = 1'b0; m_owner = 0; m_last = 6; m_age = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!m_held) begin
                m_w = pick(Req, m_last, -1);
                if (m_w >= 0) begin
                    m_held = 1'b1; m_owner = m_w; m_last = m_w; m_age = 0;
                end
            end else begin
                m_expire = TO_EN && !Done && (m_age == TO_CYC - 1);
                if (Done || m_expire) begin
                    m_to = m_expire;
                    m_w  = pick(Req, m_last, m_owner);
                    if (m_w >= 0) begin
                        m_owner = m_w; m_last = m_w; m_age = 0;
                    end else begin
                        m_held = 1'b0;
                    end
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    logic [6:0] last_grant_seen = '0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_grant",   32'(Grant),   32'(exp_grant()));
            chk("cyc_select",  32'(Select),  32'(exp_sel()));
            chk("cyc_valid",   32'(Valid),   32'(m_held));
            chk("cyc_timeout", 32'(Timeout), 32'(m_to));
            if (Grant !== last_grant_seen && Grant != 7'd0)
                $display("txn t=%0t grant=%b select=%0d", $time, Grant, Select);
            last_grant_seen = Grant;
        end
    end

    // Literal expectation checked against both the DUT and the model.
    task automatic step_chk(string name, logic [6:0] g, logic [2:0] s, logic v);
        chk({name, "_grant"},  32'(Grant),  32'(g));
        chk({name, "_select"}, 32'(Select), 32'(s));
        chk({name, "_valid"},  32'(Valid),  32'(v));
        chk({name, "_model"},  32'(exp_sel()), 32'(s));
        $display("step %s grant=%b select=%0d valid=%0d", name, Grant, Select, Valid);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        cmp_en = 1'b1;
        step_chk("reset", 7'd0, 3'd7, 1'b0);
        chk("reset_timeout", 32'(Timeout), 32'd0);
        reset_n = 1'b1;

        // Single request, then completion.
        Req = 7'b0000100;
        tick();
        step_chk("single", 7'b0000100, 3'd2, 1'b1);
        Req = '0; Done = 1'b1;
        tick();
        step_chk("single_done", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;

        // All requesting, Done every cycle: back-to-back rotation.
        do_reset();
        Req = 7'h7f; Done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            step_chk("rotate", 7'd1 << (i % 7), 3'(i % 7), 1'b1);
        end
        Req = '0;
        tick();
        step_chk("rotate_idle", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;

        // Grant held while its request drops.
        Req = 7'b0100000;
        tick();
        step_chk("hold", 7'b0100000, 3'd5, 1'b1);
        Req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            step_chk("hold_noreq", 7'b0100000, 3'd5, 1'b1);
        end
        Done = 1'b1;
        tick();
        step_chk("hold_done", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;

        // Wrap-around fairness between 0 and 6.
        do_reset();
        Req = 7'b1000001;
        tick();
        step_chk("wrap0", 7'b0000001, 3'd0, 1'b1);
        Done = 1'b1;
        tick();
        step_chk("wrap6", 7'b1000000, 3'd6, 1'b1);
        tick();
        step_chk("wrap0b", 7'b0000001, 3'd0, 1'b1);
        Req = '0;
        tick();
        step_chk("wrap_idle", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;

        // Asynchronous reset in BUSY.
        do_reset();
        Req = 7'b0001000;
        tick();
        step_chk("arst_busy", 7'b0001000, 3'd3, 1'b1);
        #2 reset_n = 1'b0;
        #1 step_chk("arst_drop", 7'd0, 3'd7, 1'b0);
        #4 reset_n = 1'b1;
        tick();
        step_chk("arst_regrant", 7'b0001000, 3'd3, 1'b1);
        Req = '0; Done = 1'b1;
        tick();
        step_chk("arst_idle", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Watchdog revokes a stuck grant after TO_CYC cycles.
        do_reset();
        Req = 7'b0000010;
        tick();
        step_chk("wd_grant", 7'b0000010, 3'd1, 1'b1);
        Req = 7'b0000110;
        for (int i = 1; i < TO_CYC; i++) begin
            tick();
            chk("wd_quiet", 32'(Timeout), 32'd0);
            step_chk("wd_held", 7'b0000010, 3'd1, 1'b1);
        end
        tick();
        chk("wd_pulse", 32'(Timeout), 32'd1);
        step_chk("wd_moved", 7'b0000100, 3'd2, 1'b1);
        tick();
        chk("wd_pulse_end", 32'(Timeout), 32'd0);
        Req = '0; Done = 1'b1;
        tick();
        step_chk("wd_idle", 7'd0, 3'd7, 1'b0);
        Done = 1'b0;
`endif

        // Randomized traffic with occasional mid-cycle async resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       Req = '0;
                1:       Req = 7'd1 << $urandom_range(0, 6);
                default: Req = 7'($urandom);
            endcase
            Done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, grant watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Req  input  7  per-requester request for the shared 32-bit 7:1 write-back mux; bit i is mux input Ii.
REQ-005 Done  input  1  consumer (register-file write) accepted the current transfer this cycle.
REQ-006 Grant  output  7  one-hot grant, all-zero when no grant is held.
REQ-007 Select  output  3  mux select, equal to the granted index; 3'b111 when idle, so the mux outputs 32'd0.
REQ-008 Valid  output  1  high while a grant is held, meaning the mux output is meaningful.
REQ-009 Timeout  output  1  one-cycle pulse when the watchdog revokes a grant; tied to 0 without ARB_TIMEOUT_EN.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 IDLE: if Req is nonzero at a clock edge, the FSM SHALL move to BUSY with Grant, Select and Valid registered on that edge; latency from Req to Grant is 1 cycle.
REQ-012 Winner selection SHALL be round-robin: search starts at index (Ptr+1) mod 7 and wraps 6->0; Ptr is the last granted index.
REQ-013 Ptr SHALL update to the granted index when a grant is issued.
REQ-014 BUSY: Grant and Select SHALL stay constant until Done=1, even if the granted Req bit deasserts.
REQ-015 BUSY with Done=1 and any other Req bit set: the FSM SHALL issue the next grant on the same edge (back-to-back, no idle bubble), and the finishing requester has lowest priority.
REQ-016 BUSY with Done=1 and no other Req bit set: the FSM SHALL go to IDLE, with Select=3'b111 and Valid=0 on the next cycle, even if the finishing requester still requests.
REQ-017 Done while in IDLE SHALL be ignored.
REQ-018 Grant SHALL never have more than one bit set; Select SHALL never take a value in 0..6 while Valid=0.

Reset
REQ-019 While reset_n=0: state=IDLE, Grant=7'b0, Select=3'b111, Valid=0, Timeout=0, Ptr=6 (index 0 has highest priority first), watchdog counter=0.
REQ-020 Reset asserted in BUSY SHALL drop the grant immediately (asynchronously); no transfer completes.
REQ-021 After reset_n rises, the first grant SHALL occur no earlier than the first rising edge of clk with reset_n=1.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: a counter SHALL clear on each grant and increment each BUSY cycle without Done.
REQ-023 Macro ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1 without Done, the FSM SHALL revoke the grant, pulse Timeout for one cycle and arbitrate as in REQ-015/016.
REQ-024 Macro ARB_TIMEOUT_EN undefined: no counter logic; a grant SHALL be held indefinitely until Done; Timeout=0.

Structure
REQ-025 Package mux_arb_pkg SHALL hold NUM_REQ=7, SEL_W=3, SEL_NONE=3'b111 and the state enum (IDLE, BUSY).
REQ-026 Round-robin search SHALL live in one combinational sub-module, rr_priority_7 (inputs Req and Ptr; outputs index and found flag).
REQ-027 Total RTL SHALL be about 120-250 lines.

Verification
REQ-028 Reset, then Req=7'b0000100 -> next cycle Grant=7'b0000100, Select=2, Valid=1; Done pulse -> next cycle Select=7, Valid=0.
REQ-029 Req=7'b1111111 held, Done every cycle -> Select sequence 0,1,2,3,4,5,6,0 with no idle cycles.
REQ-030 Grant on 5; Req[5] drops for 3 cycles without Done -> Select stays 5 and Valid=1 until Done.
REQ-031 Req=7'b1000001 after Ptr=6 -> grant 0, Done -> grant 6, Done -> grant 0 (wrap-around fairness).
REQ-032 reset_n=0 mid-BUSY on Select=3 -> Grant=0, Select=7 immediately; after release with Req=7'b0001000 -> grant 3 one cycle later.
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: grant on 1 with no Done -> Timeout pulses exactly 4 cycles after grant, grant moves to next pending requester or to IDLE.
